// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Access latched in IDLE and held unchanged until the controller returns to IDLE.
  typedef struct packed {
    logic        we;
    logic [29:0] waddr;
    logic [1:0]  lo;
    logic [1:0]  size;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: access_legal = 1'b1;
      SIZE_HALF: access_legal = ~lo[0];
      SIZE_WORD: access_legal = (lo == 2'b00);
      default:   access_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store replication and load extraction.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'b0, 8'(rword_i >> {lo_i, 3'b000})};
      end
      SIZE_HALF: begin
        be_o    = lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'b0, (lo_i[1] ? rword_i[31:16] : rword_i[15:0])};
      end
      SIZE_WORD: be_o = 4'b1111;
      default:   be_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller with a valid/ready request channel.
// Optional WAIT_RESP watchdog enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  size_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        one_op, legal_req, to_hit;
  logic [1:0]  ln_size, ln_lo;
  logic [3:0]  ln_be;
  logic [31:0] ln_wdata, ln_rdata;

  assign one_op    = mem_read_in ^ mem_write_in;
  assign legal_req = one_op & access_legal(size_in, addr_in[1:0]);

  // One aligner serves both directions: live inputs while IDLE, latched access otherwise.
  assign ln_size = (state_q == IDLE) ? size_in      : req_q.size;
  assign ln_lo   = (state_q == IDLE) ? addr_in[1:0] : req_q.lo;

  mem_lane_align u_lane (
    .size_i  (ln_size),
    .lo_i    (ln_lo),
    .wdata_i (wdata_in),
    .rword_i (mem_resp_rdata),
    .be_o    (ln_be),
    .wdata_o (ln_wdata),
    .rdata_o (ln_rdata)
  );

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside WAIT_RESP, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    cnt_q <= '0;
    else if (state_q != WAIT_RESP) cnt_q <= '0;
    else                           cnt_q <= cnt_q + 1'b1;
  end

  assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read_in | mem_write_in) begin
          if (legal_req) begin
            state_d     = REQ;
            req_d.we    = mem_write_in;
            req_d.waddr = addr_in[31:2];
            req_d.lo    = addr_in[1:0];
            req_d.size  = size_in;
            req_d.be    = ln_be;
            req_d.wdata = ln_wdata;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ:       if (mem_req_ready) state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          state_d = DONE;
          if (!req_q.we) rdata_d = ln_rdata;
        end else if (to_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Gated by reset so a request sitting on the inputs cannot stall while held in reset.
  assign stall_out     = reset & (((state_q == IDLE) & legal_req) |
                                  (state_q == REQ) | (state_q == WAIT_RESP));
  assign done_out      = (state_q == DONE);
  assign err_out       = err_q;
  assign rdata_out     = rdata_q;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_we    = req_q.we;
  assign mem_req_addr  = {req_q.waddr, 2'b00};
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_be    = req_q.be;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl; the timeout case runs when MEM_CTRL_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = TIMEOUT_DEFAULT;
`endif

  logic        clk, reset;
  logic        mem_read_in, mem_write_in;
  logic [31:0] addr_in, wdata_in;
  logic [1:0]  size_in;
  logic        stall_out, done_out, err_out;
  logic [31:0] rdata_out;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .size_in(size_in),
    .stall_out(stall_out), .done_out(done_out), .rdata_out(rdata_out), .err_out(err_out),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done/err pulse must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && (done_out || err_out)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {30'b0, done_out, err_out}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_err", err_out, e.err);
        chk("sb_done", done_out, !e.err);
        if (done_out && e.rd) chk("sb_rdata", rdata_out, e.rdata);
      end
    end
  end

  task automatic idle_in();
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    addr_in = '0; wdata_in = '0; size_in = '0;
  endtask

  // Junk on the request inputs while an access is in flight must not disturb it.
  task automatic scramble();
    mem_read_in  = 1'($urandom);
    mem_write_in = 1'($urandom);
    addr_in      = $urandom;
    wdata_in     = $urandom;
    size_in      = 2'($urandom);
  endtask

  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                        input int rdy_dly, input logic [31:0] resp, input logic exp_err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    exp_t e;
    @(negedge clk);
    mem_read_in = rd; mem_write_in = wr; addr_in = addr; size_in = size; wdata_in = wd;
    e.err = exp_err; e.rd = rd; e.rdata = exp_rd;
    sb.push_back(e);
    #1 chk({tag, "_stall_idle"}, stall_out, !exp_err);
    @(posedge clk); #1;
    if (exp_err) begin
      idle_in();
      chk({tag, "_no_valid"}, mem_req_valid, 1'b0);
      chk({tag, "_no_stall"}, stall_out, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_no_valid2"}, mem_req_valid, 1'b0);
      return;
    end
    scramble();
    for (int i = 0; i <= rdy_dly; i++) begin
      chk({tag, "_valid"}, mem_req_valid, 1'b1);
      chk({tag, "_addr"}, mem_req_addr, {addr[31:2], 2'b00});
      chk({tag, "_be"}, mem_req_be, exp_be);
      chk({tag, "_wdata"}, mem_req_wdata, exp_wd);
      chk({tag, "_we"}, mem_req_we, wr);
      chk({tag, "_stall_req"}, stall_out, 1'b1);
      mem_req_ready = (i == rdy_dly);
      if (i < rdy_dly) begin
        @(posedge clk); #1;
        scramble();
      end
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk({tag, "_valid_drop"}, mem_req_valid, 1'b0);
    chk({tag, "_stall_wait"}, stall_out, 1'b1);
    mem_resp_valid = 1'b1; mem_resp_rdata = resp;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
    idle_in();
    chk({tag, "_done"}, done_out, 1'b1);
    chk({tag, "_stall_done"}, stall_out, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done_out, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    mem_read_in = 1'b1; mem_write_in = 1'b0; addr_in = 32'h100; size_in = SIZE_WORD; wdata_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_done", done_out, 1'b0);
    chk("rst_err", err_out, 1'b0);
    chk("rst_valid", mem_req_valid, 1'b0);
    chk("rst_we", mem_req_we, 1'b0);
    chk("rst_be", mem_req_be, 4'b0);
    chk("rst_rdata", rdata_out, 32'b0);
    idle_in();
    reset = 1'b1;

    access("wld",   1, 0, 32'h100, SIZE_WORD, 32'h0,        0, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
    access("bst",   0, 1, 32'h103, SIZE_BYTE, 32'h5A,       0, 32'h0,        0, 4'b1000, 32'h5A5A5A5A, 32'h0);
    access("hld",   1, 0, 32'h202, SIZE_HALF, 32'h0,        5, 32'hBEEF1234, 0, 4'b1100, 32'h0,        32'h0000BEEF);
    access("mis",   1, 0, 32'h101, SIZE_WORD, 32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0);
    access("bld1",  1, 0, 32'h101, SIZE_BYTE, 32'h0,        1, 32'h11223344, 0, 4'b0010, 32'h0,        32'h00000033);
    access("bld2",  1, 0, 32'h102, SIZE_BYTE, 32'hFF,       0, 32'h11223344, 0, 4'b0100, 32'hFFFFFFFF, 32'h00000022);
    access("hld0",  1, 0, 32'h200, SIZE_HALF, 32'h0,        0, 32'hBEEF1234, 0, 4'b0011, 32'h0,        32'h00001234);
    access("hst",   0, 1, 32'h200, SIZE_HALF, 32'hABCD1234, 0, 32'h0,        0, 4'b0011, 32'h12341234, 32'h0);
    access("wst",   0, 1, 32'h300, SIZE_WORD, 32'hCAFEF00D, 2, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0);
    access("sz11",  1, 0, 32'h100, 2'b11,     32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0);
    access("hmis",  0, 1, 32'h201, SIZE_HALF, 32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0);
    access("rdwr",  1, 1, 32'h100, SIZE_WORD, 32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0);

    // A response with nothing outstanding must be ignored.
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_resp_done", done_out, 1'b0);
    chk("idle_resp_stall", stall_out, 1'b0);
    mem_resp_valid = 1'b0;

    // Reset while waiting for a response; the late response must not complete anything.
    @(negedge clk);
    mem_read_in = 1'b1; addr_in = 32'h400; size_in = SIZE_WORD;
    @(posedge clk); #1;
    idle_in();
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("mid_stall_wait", stall_out, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_stall", stall_out, 1'b0);
    chk("mid_rst_done", done_out, 1'b0);
    chk("mid_rst_err", err_out, 1'b0);
    chk("mid_rst_valid", mem_req_valid, 1'b0);
    chk("mid_rst_we", mem_req_we, 1'b0);
    chk("mid_rst_be", mem_req_be, 4'b0);
    chk("mid_rst_rdata", rdata_out, 32'b0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (2) begin
      chk("late_resp_done", done_out, 1'b0);
      chk("late_resp_valid", mem_req_valid, 1'b0);
      @(posedge clk); #1;
    end

    access("post",  1, 0, 32'h104, SIZE_WORD, 32'h0,        0, 32'h0BADF00D, 0, 4'b1111, 32'h0,        32'h0BADF00D);

`ifdef MEM_CTRL_TIMEOUT_EN
    begin
      exp_t e;
      int   n;
      @(negedge clk);
      mem_read_in = 1'b1; addr_in = 32'h500; size_in = SIZE_WORD;
      e.err = 1'b1; e.rd = 1'b1; e.rdata = '0;
      sb.push_back(e);
      @(posedge clk); #1;
      idle_in();
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      n = 0;
      while (!err_out && n < 20) begin
        @(posedge clk); #1;
        n++;
        chk("to_no_done", done_out, 1'b0);
      end
      chk("to_cycles", n, TO);
      chk("to_stall", stall_out, 1'b0);
      chk("to_valid", mem_req_valid, 1'b0);
      @(posedge clk); #1;
      chk("to_err_pulse", err_out, 1'b0);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
